// File: rtl/vram_blit_arbiter.sv
// rtl/vram_blit_arbiter.sv - sprite blitter from picture ROM into VRAM, sharing the VRAM write port with the CPU
module vram_blit_arbiter #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ROM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_vram_we,
    input  logic [17:0]       cpu_vram_addr,
    input  logic [11:0]       cpu_vram_data,
    input  logic              start,
    input  logic              abort,
    input  logic [ROM_AW-1:0] src_base,
    input  logic [8:0]        blit_w,
    input  logic [8:0]        blit_h,
    input  logic [9:0]        dst_x,
    input  logic [8:0]        dst_y,
    input  logic              key_en,
    input  logic [11:0]       key_color,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic              vram_we,
    output logic [17:0]       vram_addr,
    output logic [11:0]       vram_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [8:0]        w_q;
    logic [8:0]        h_q;
    logic [9:0]        dx_q;
    logic [8:0]        dy_q;
    logic              key_en_q;
    logic [11:0]       key_q;
    logic [8:0]        row;
    logic [8:0]        col;
    logic [ROM_AW-1:0] rom_addr_q;
    logic [11:0]       pix_q;

    logic              last_col;
    logic              last_px;
    logic              advance;
    logic [10:0]       px;
    logic [9:0]        py;
    logic [19:0]       lin_addr;
    logic              in_bounds;
    logic              transparent;
    logic              blit_wr;

    assign last_col    = (col == w_q - 9'd1);
    assign last_px     = last_col && (row == h_q - 9'd1);
    assign advance     = (state == S_WRITE) && !cpu_vram_we && !abort;

    assign px          = {1'b0, dx_q} + {2'b00, col};
    assign py          = {1'b0, dy_q} + {1'b0, row};
    assign lin_addr    = 20'(py) * 20'(H_RES) + 20'(px);
    assign in_bounds   = (px < 11'(H_RES)) && (py < 10'(V_RES));
    assign transparent = key_en_q && (pix_q == key_q);
    assign blit_wr     = advance && in_bounds && !transparent;

    // CPU wins the write port outright; the blitter simply stalls in WRITE.
    assign vram_we   = cpu_vram_we ? 1'b1 : blit_wr;
    assign vram_addr = cpu_vram_we ? cpu_vram_addr : lin_addr[17:0];
    assign vram_data = cpu_vram_we ? cpu_vram_data : pix_q;

    assign rom_addr  = rom_addr_q;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE) && !abort;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (blit_w == 9'd0 || blit_h == 9'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_nx = S_LATCH;
            S_LATCH: state_nx = S_WRITE;
            S_WRITE: begin
                if (!cpu_vram_we) begin
                    state_nx = last_px ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_nx = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            w_q        <= '0;
            h_q        <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            key_en_q   <= 1'b0;
            key_q      <= '0;
            row        <= '0;
            col        <= '0;
            rom_addr_q <= '0;
            pix_q      <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                w_q        <= blit_w;
                h_q        <= blit_h;
                dx_q       <= dst_x;
                dy_q       <= dst_y;
                key_en_q   <= key_en;
                key_q      <= key_color;
                row        <= '0;
                col        <= '0;
                rom_addr_q <= src_base;
            end
            // Row stride equals the width, so src + row*w + col just steps by one per pixel.
            if (advance) begin
                rom_addr_q <= rom_addr_q + {{(ROM_AW-1){1'b0}}, 1'b1};
                if (last_col) begin
                    col <= '0;
                    row <= row + 9'd1;
                end else begin
                    col <= col + 9'd1;
                end
            end
            if (state == S_LATCH) begin
                pix_q <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_vram_blit_arbiter.sv
// tb/tb_vram_blit_arbiter.sv - randomized self-checking bench for vram_blit_arbiter
module tb_vram_blit_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_vram_we = 1'b0;
    logic [17:0] cpu_vram_addr = '0;
    logic [11:0] cpu_vram_data = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [16:0] src_base = '0;
    logic [8:0]  blit_w = '0;
    logic [8:0]  blit_h = '0;
    logic [9:0]  dst_x = '0;
    logic [8:0]  dst_y = '0;
    logic        key_en = 1'b0;
    logic [11:0] key_color = '0;
    logic [16:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic        vram_we;
    logic [17:0] vram_addr;
    logic [11:0] vram_data;
    logic        busy;
    logic        done;

    vram_blit_arbiter #(.H_RES(320), .V_RES(240), .ROM_AW(17)) dut (
        .clk(clk), .rst(rst),
        .cpu_vram_we(cpu_vram_we), .cpu_vram_addr(cpu_vram_addr), .cpu_vram_data(cpu_vram_data),
        .start(start), .abort(abort), .src_base(src_base),
        .blit_w(blit_w), .blit_h(blit_h), .dst_x(dst_x), .dst_y(dst_y),
        .key_en(key_en), .key_color(key_color),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [11:0] rom_mem [1024];
    always @(posedge clk) rom_data <= rom_mem[rom_addr[9:0]];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Model: a blit of N pixels is a step count s in 0..3N; pixel s/3, phase s%3, s==3N is the done cycle.
    int m_active = 0, m_s = 0, m_n = 0, m_src = 0, m_w = 0, m_h = 0, m_dx = 0, m_dy = 0, m_ken = 0, m_key = 0;
    int k, prow, pcol, px, py, e_rom;
    logic e_busy, e_done, b_we, chk_rom;
    logic [17:0] b_addr;
    logic [11:0] b_data, pd;

    int busy_cnt = 0, done_cnt = 0;
    int wr_addr[$];
    int wr_data[$];

    always @(negedge clk) begin
        e_busy = 0; e_done = 0; b_we = 0; b_addr = '0; b_data = '0; chk_rom = 0; e_rom = 0;
        if (!rst) m_active = 0;
        if (rst && m_active != 0) begin
            e_busy = 1;
            if (m_s == 3 * m_n) begin
                e_done = !abort;
            end else begin
                k = m_s / 3;
                if (m_s % 3 == 0) begin
                    chk_rom = 1;
                    e_rom = (m_src + k) & 32'h1FFFF;
                end
                if (m_s % 3 == 2 && !cpu_vram_we && !abort) begin
                    prow = k / m_w;
                    pcol = k % m_w;
                    pd = rom_mem[(m_src + k) & 1023];
                    px = m_dx + pcol;
                    py = m_dy + prow;
                    b_we = (px < 320) && (py < 240) && !(m_ken != 0 && int'(pd) == m_key);
                    b_addr = 18'(py * 320 + px);
                    b_data = pd;
                end
            end
        end
        check("busy", busy, e_busy);
        check("done", done, e_done);
        if (cpu_vram_we) begin
            check("cpu_we", vram_we, 1);
            check("cpu_addr", vram_addr, cpu_vram_addr);
            check("cpu_data", vram_data, cpu_vram_data);
        end else begin
            check("blit_we", vram_we, b_we);
            if (b_we) begin
                check("blit_addr", vram_addr, b_addr);
                check("blit_data", vram_data, b_data);
            end
        end
        if (chk_rom) check("rom_addr", rom_addr, e_rom);
        if (rst) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (vram_we && !cpu_vram_we) begin
                wr_addr.push_back(int'(vram_addr));
                wr_data.push_back(int'(vram_data));
            end
            if (m_active == 0) begin
                if (start) begin
                    m_active = 1; m_s = 0;
                    m_src = int'(src_base); m_w = int'(blit_w); m_h = int'(blit_h);
                    m_dx = int'(dst_x); m_dy = int'(dst_y);
                    m_ken = int'(key_en); m_key = int'(key_color);
                    m_n = m_w * m_h;
                end
            end else if (abort) begin
                m_active = 0;
            end else if (m_s == 3 * m_n) begin
                m_active = 0;
            end else if (!(m_s % 3 == 2 && cpu_vram_we)) begin
                m_s++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        busy_cnt = 0;
        done_cnt = 0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic do_start(input int src, input int w, input int h, input int dx, input int dy,
                            input int ken, input int key);
        src_base = 17'(src); blit_w = 9'(w); blit_h = 9'(h);
        dst_x = 10'(dx); dst_y = 9'(dy); key_en = ken[0]; key_color = 12'(key);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("wait_idle_timeout", busy, 0);
    endtask

    task automatic check_base_writes(input string tag);
        check({tag, "_nwr"}, wr_addr.size(), 4);
        check({tag, "_a0"}, wr_addr[0], 1610); check({tag, "_d0"}, wr_data[0], 'h111);
        check({tag, "_a1"}, wr_addr[1], 1611); check({tag, "_d1"}, wr_data[1], 'h222);
        check({tag, "_a2"}, wr_addr[2], 1930); check({tag, "_d2"}, wr_data[2], 'h333);
        check({tag, "_a3"}, wr_addr[3], 1931); check({tag, "_d3"}, wr_data[3], 'h444);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, h, src, dx, dy, n;
        for (int i = 0; i < 1024; i++) rom_mem[i] = 12'($urandom);
        rom_mem['h100] = 12'h111; rom_mem['h101] = 12'h222;
        rom_mem['h102] = 12'h333; rom_mem['h103] = 12'h444;
        rom_mem['h104] = 12'h555; rom_mem['h105] = 12'h666;
        cpu_vram_we = 1'b1; cpu_vram_addr = 18'h00123; cpu_vram_data = 12'hABC;
        #1 rst = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_vram_we", vram_we, 1);
        check("rst_vram_addr", vram_addr, 'h123);
        check("rst_vram_data", vram_data, 'hABC);
        tick(); tick();
        rst = 1'b1; cpu_vram_we = 1'b0;
        tick();

        clear_logs(); do_start('h100, 2, 2, 10, 5, 0, 0); wait_idle(100);
        check("basic_busy", busy_cnt, 13); check("basic_done", done_cnt, 1);
        check_base_writes("basic");

        clear_logs(); do_start('h100, 2, 2, 10, 5, 1, 'h222); wait_idle(100);
        check("key_busy", busy_cnt, 13); check("key_nwr", wr_addr.size(), 3);
        check("key_a1", wr_addr[1], 1930);

        clear_logs(); do_start('h100, 2, 2, 10, 5, 0, 0);
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            cpu_vram_we = 1'b1; cpu_vram_addr = 18'h3FFF0 + 18'(i); cpu_vram_data = 12'h900 + 12'(i);
            tick();
        end
        cpu_vram_we = 1'b0;
        wait_idle(100);
        check("stall_busy", busy_cnt, 17);
        check_base_writes("stall");

        clear_logs(); do_start('h100, 2, 2, 319, 239, 0, 0); wait_idle(100);
        check("clip_busy", busy_cnt, 13); check("clip_nwr", wr_addr.size(), 1);
        check("clip_a0", wr_addr[0], 76799); check("clip_d0", wr_data[0], 'h111);

        clear_logs(); do_start('h100, 0, 3, 10, 5, 0, 0); wait_idle(100);
        check("w0_busy", busy_cnt, 1); check("w0_done", done_cnt, 1); check("w0_nwr", wr_addr.size(), 0);

        clear_logs(); do_start('h100, 2, 2, 10, 5, 0, 0);
        tick(); tick();
        do_start('h0, 4, 4, 0, 0, 0, 0);
        wait_idle(100);
        check("restart_busy", busy_cnt, 13); check("restart_done", done_cnt, 1);
        check_base_writes("restart");

        clear_logs(); do_start('h100, 3, 2, 10, 5, 0, 0);
        tick(); tick(); tick(); tick();
        abort = 1'b1; tick(); abort = 1'b0;
        wait_idle(100);
        check("abort_busy", busy_cnt, 5); check("abort_done", done_cnt, 0);
        check("abort_nwr", wr_addr.size(), 1);

        clear_logs(); do_start('h100, 2, 2, 10, 5, 0, 0);
        tick(); tick(); tick();
        rst = 1'b0; #1;
        check("midrst_busy", busy, 0); check("midrst_done", done, 0);
        tick(); rst = 1'b1; tick();
        check("midrst_done_cnt", done_cnt, 0);

        for (int it = 0; it < 40; it++) begin
            w = $urandom_range(0, 5); h = $urandom_range(0, 4);
            src = (it % 8 == 3) ? 'h1FFFE : int'($urandom_range(0, 900));
            dx = $urandom_range(0, 1) ? int'($urandom_range(300, 340)) : int'($urandom_range(0, 319));
            dy = $urandom_range(0, 1) ? int'($urandom_range(230, 250)) : int'($urandom_range(0, 239));
            do_start(src, w, h, dx, dy, int'($urandom_range(0, 1)),
                     int'(rom_mem[(src + int'($urandom_range(0, 3))) & 1023]));
            n = 0;
            while (busy && n < 500) begin
                cpu_vram_we = ($urandom_range(0, 4) == 0);
                cpu_vram_addr = 18'($urandom); cpu_vram_data = 12'($urandom);
                abort = ($urandom_range(0, 60) == 0);
                start = ($urandom_range(0, 10) == 0);
                tick();
                n++;
            end
            cpu_vram_we = 1'b0; abort = 1'b0; start = 1'b0;
            wait_idle(500);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
